// File: rtl/md_pkg.sv
// md_pkg: shared types for the EXE-stage multiply/divide sequencer.
package md_pkg;

    localparam int DIV_ITERS = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        MD_EXT_NONE = 2'd0,
        MD_EXT_ADD  = 2'd1,
        MD_EXT_SUB  = 2'd2
    } md_ext_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    // Result bundle committed to HILO on md_finish
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        md_ext_t     ext;
    } md_res_t;

    // Signed ops sign-extend multiply operands and take magnitudes for divide
    function automatic logic op_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    function automatic md_ext_t op_ext(input md_op_t op);
        case (op)
            MD_MADD, MD_MADDU: return MD_EXT_ADD;
            MD_MSUB, MD_MSUBU: return MD_EXT_SUB;
            default:           return MD_EXT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// md_div_iter: restoring divider datapath, one quotient bit per step.
// {remainder, quotient} share one 64-bit shift register; the quotient
// bits shift in from the bottom as the dividend bits shift out the top.
module md_div_iter
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] rem_nxt,
    output logic [31:0] quo_nxt
);

    logic [63:0] acc_q, acc_d, step_val;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] trial;

    // One restoring step: trial-subtract divisor from {rem, next dividend bit}
    always_comb begin
        trial = acc_q[63:31] - {1'b0, dvs_q};
        if (!trial[32]) step_val = {trial[31:0], acc_q[30:0], 1'b1};
        else            step_val = {acc_q[62:0], 1'b0};
        acc_d = acc_q;
        dvs_d = dvs_q;
        if (load) begin
            acc_d = {32'd0, dividend};
            dvs_d = divisor;
        end else if (step) begin
            acc_d = step_val;
        end
        rem_nxt = step_val[63:32];
        quo_nxt = step_val[31:0];
    end

    // Shift register and divisor hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            dvs_q <= '0;
        end else begin
            acc_q <= acc_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/exe_muldiv_ctrl.sv
// exe_muldiv_ctrl: EXE-stage mul/div sequencer. Stalls the pipe while a
// multiply (MUL_LAT cycles) or divide (32 steps) runs, then pulses
// md_finish once and parks in DONE until the EXE register advances.
// Optional build macro: DIV_EARLY_OUT_EN (skip iterations for trivial divides).
module exe_muldiv_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  md_op_t      req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        pipe_adv,
    output logic        md_stall,
    output logic        md_finish,
    output logic [31:0] md_hi,
    output logic [31:0] md_lo,
    output md_ext_t     md_extend
);

    md_state_t   state_q, state_d;
    md_op_t      op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [4:0]  cnt_q, cnt_d;
    md_res_t     res_q, res_d;
    logic        first_q, first_d;

    logic        accept, in_div, early_out;
    logic [31:0] mag_a, mag_b;
    logic [63:0] mul_a, mul_b, prod;
    logic        div_load, div_step, neg_q, neg_r;
    logic [31:0] div_rem, div_quo;

    md_div_iter u_div (
        .clk      (clk),
        .resetn   (resetn),
        .load     (div_load),
        .step     (div_step),
        .dividend (mag_a),
        .divisor  (mag_b),
        .rem_nxt  (div_rem),
        .quo_nxt  (div_quo)
    );

    // Request decode, divide magnitudes and multiply/sign-fixup terms
    always_comb begin
        accept = (state_q == ST_IDLE) && req_valid && !flush;
        in_div = (req_op == MD_DIV) || (req_op == MD_DIVU);
        mag_a  = (req_op == MD_DIV && src_a[31]) ? -src_a : src_a;
        mag_b  = (req_op == MD_DIV && src_b[31]) ? -src_b : src_b;
`ifdef DIV_EARLY_OUT_EN
        early_out = in_div && ((src_b == 32'd0) || (mag_a < mag_b));
`else
        early_out = 1'b0;
`endif
        mul_a = op_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        mul_b = op_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod  = mul_a * mul_b;
        neg_q = (op_q == MD_DIV) && (a_q[31] ^ b_q[31]);
        neg_r = (op_q == MD_DIV) && a_q[31];
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state; flush wins from every state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = early_out ? ST_DONE : (in_div ? ST_DIV : ST_MUL);
            ST_MUL:  if (cnt_q == 5'd0) state_d = ST_DONE;
            ST_DIV:  if (cnt_q == 5'd0) state_d = ST_DONE;
            ST_DONE: if (pipe_adv) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    // FSM outputs and datapath control: operand latch, counter, result capture
    always_comb begin
        md_stall  = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
        md_finish = (state_q == ST_DONE) && first_q && !flush;
        first_d   = (state_d == ST_DONE) && (state_q != ST_DONE);
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        div_load  = 1'b0;
        div_step  = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                op_d     = req_op;
                a_d      = src_a;
                b_d      = src_b;
                div_load = in_div;
                cnt_d    = in_div ? 5'(DIV_ITERS - 1) : 5'(MUL_LAT - 1);
`ifdef DIV_EARLY_OUT_EN
                if (early_out) begin
                    // Zero divisor mirrors the full restoring result after fixup
                    res_d.hi  = src_a;
                    res_d.lo  = (src_b != 32'd0) ? 32'd0 :
                                ((req_op == MD_DIV && src_a[31]) ? 32'd1 : 32'hFFFF_FFFF);
                    res_d.ext = MD_EXT_NONE;
                end
`endif
            end
            ST_MUL: begin
                if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
                else if (!flush) begin
                    res_d.hi  = prod[63:32];
                    res_d.lo  = prod[31:0];
                    res_d.ext = op_ext(op_q);
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
                else if (!flush) begin
                    res_d.hi  = neg_r ? -div_rem : div_rem;
                    res_d.lo  = neg_q ? -div_quo : div_quo;
                    res_d.ext = MD_EXT_NONE;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            first_q <= 1'b0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            first_q <= first_d;
        end
    end

    assign md_hi     = res_q.hi;
    assign md_lo     = res_q.lo;
    assign md_extend = res_q.ext;

endmodule

// File: doc/exe_muldiv_ctrl.md
# exe_muldiv_ctrl

Sequencer for the EXE-stage multiply/divide resource. It accepts one MULT/DIV/MADD/MSUB-class operation from the EXE register and runs a fixed-latency multiply or a 32-step iterative divide. While the operation runs it holds the pipeline with a stall. On completion it delivers a single finish pulse with HI/LO results and an accumulate mode for the HILO register. It guarantees exactly one HILO update per instruction, even when EXE is held after completion, and abandons work on flush.

## Interface
- MUL_LAT, 2: multiply latency in MUL-state cycles; legal range 1..8.
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  EXE holds a mul/div-class instruction.
- req_op  in  3  md_op_t: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- src_a  in  32  forwarded rs operand (dividend / multiplicand).
- src_b  in  32  forwarded rt operand (divisor / multiplier).
- flush  in  1  exception/flush of EXE; abandons the current operation.
- pipe_adv  in  1  EXE register advances this cycle.
- md_stall  out  1  hold IF..EXE.
- md_finish  out  1  one-cycle pulse; HILO must commit md_hi/md_lo.
- md_hi  out  32  high product word / remainder.
- md_lo  out  32  low product word / quotient.
- md_extend  out  2  md_ext_t: NONE, ADD (MADD*), SUB (MSUB*); valid with md_finish.

## Operation
- The FSM has four states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On req_valid & ~flush, latch op, src_a and src_b.
  - Go to MUL for MULT*/MADD*/MSUB*; go to DIV for DIV*.
- MUL:
  - A counter loads MUL_LAT-1 and decrements.
  - At zero, register the 64-bit product and go to DONE.
  - Signed ops (MULT, MADD, MSUB) sign-extend both operands; unsigned ops zero-extend.
- DIV:
  - Operate on magnitudes of the latched operands (magnitudes only for DIV; DIVU uses raw values).
  - md_div_iter runs one restoring step per cycle for 32 cycles.
  - Sign fixup: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Divide-by-zero result is the natural restoring outcome: md_lo = 0xFFFFFFFF, md_hi = |dividend| with sign fixup applied.
  - No exception is raised for divide-by-zero.
- DONE:
  - md_finish = 1 in the first DONE cycle only, gated by ~flush.
  - Stay in DONE until pipe_adv, then go to IDLE.
  - No re-issue occurs while EXE is held by another stall source.
- md_extend:
  - ADD for MADD/MADDU, SUB for MSUB/MSUBU, otherwise NONE.
  - Registered with the result.
- md_stall = (IDLE & req_valid & ~flush) | MUL | DIV. It is low in DONE.
- flush in any state: go to IDLE next cycle and discard the result. A flush in the first DONE cycle suppresses md_finish.
- req_valid dropping in MUL/DIV without flush is ignored and the operation completes.

## Timing
- Reset values: state IDLE, md_stall 0, md_finish 0, md_hi 0, md_lo 0, md_extend NONE, counters 0.
- Reset mid-operation returns to IDLE with no finish.
- Cycle 0 is the cycle req_valid is first seen in IDLE; md_stall is combinationally high in cycle 0.
- Multiply: MUL occupies cycles 1..MUL_LAT; DONE and md_finish fall in cycle MUL_LAT+1.
- Divide: DIV occupies cycles 1..32; md_finish falls in cycle 33.
- md_hi, md_lo and md_extend are registered and stable for every DONE cycle.
- If pipe_adv is high in the finish cycle, the next cycle is IDLE and can accept a new instruction.
- Minimum spacing between finishes is MUL_LAT+2 cycles.

## Configuration
- DIV_EARLY_OUT_EN:
  - When defined, DIV* goes directly from IDLE to DONE in cycle 1 (md_finish in cycle 1) when the divisor is zero or |dividend| < |divisor|.
  - Early-out results: quotient 0 and remainder = dividend; divide-by-zero results as in Operation.
  - When undefined, every divide takes 32 iteration cycles.

## Structure
- Package md_pkg holds md_op_t, md_ext_t, the FSM state enum, and localparam DIV_ITERS = 32.
- Sub-module md_div_iter contains the restoring divider datapath: 64-bit partial remainder/quotient shift register, step enable, and load. The FSM, counter, sign handling and output registers live in exe_muldiv_ctrl.

## Test plan
- MULTU 0xFFFFFFFF × 0x00000002, MUL_LAT=2 -> finish cycle 3; hi=0x00000001, lo=0xFFFFFFFE, extend NONE; stall high in cycles 0..2.
- DIV −7 / 2 -> finish cycle 33; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
- MSUB 3 × −4 -> finish with hi=0xFFFFFFFF, lo=0xFFFFFFF4, extend SUB.
- Finish with pipe_adv held low for 5 cycles -> exactly one md_finish pulse, outputs stable, no restart; pipe_adv then back-to-back MULT accepted next cycle.
- flush asserted in cycle 10 of a DIV -> IDLE in cycle 11, no md_finish, stall low; asserting resetn low mid-MUL gives the same result.
- With DIV_EARLY_OUT_EN, DIVU 3/5 -> finish cycle 1, lo=0, hi=3; without the macro -> finish cycle 33, same values.
